kf_noc_ni: RTL and testbench
============================

# kf_noc_ni

Tile network interface between an SNN core and the local port of its NoC router. On the transmit side it turns each local neuron firing into one spike flit per configured fan-out destination and injects them into the router's local input. On the receive side it accepts flits from the router's local output, buffers them, and delivers them to the core. It sits one per tile, directly beside the router.

## Interface
- TILE_X, 0, this tile's X coordinate (becomes src_x of injected flits; used for the receive destination check)
- TILE_Y, 0, this tile's Y coordinate
- NUM_NEURONS, 256, local neurons; spk_neuron range 0..NUM_NEURONS-1
- FANOUT_MAX, 4, fan-out table entries per neuron (power of two)
- RX_DEPTH, 4, receive FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (one clock; synchronous active-high reset)
- spk_valid  in  1  core spike event valid
- spk_ready  out  1  high only in IDLE
- spk_neuron  in  NEURON_W  firing neuron index
- inj_valid  out  1  to router in_local_valid
- inj_ready  in  1  from router in_local_ready
- inj_flit  out  spike_flit_t  to router in_local_flit
- ej_valid  in  1  from router out_local_valid
- ej_ready  out  1  to router out_local_ready
- ej_flit  in  spike_flit_t  from router out_local_flit
- dlv_valid / dlv_ready  out / in  1  delivery handshake to the core
- dlv_neuron  out  NEURON_W  target neuron_id
- dlv_src_x, dlv_src_y  out  COORD_W  originating tile
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(NUM_NEURONS*FANOUT_MAX)  address = neuron*FANOUT_MAX + slot
- cfg_wdata  in  fanout_entry_t  {valid, dest_x, dest_y, dest_neuron}
- init_done  out  1  table clear finished
- stat_unrouted  out  16  spikes with no valid entry, saturating
- stat_misroute  out  16  received flits not addressed to this tile, saturating

## Operation
- Transmit FSM states: INIT, IDLE, LOOKUP, SEND.
- INIT (entered from reset): writes zero to every table address, one per cycle, from 0 up to NUM_NEURONS*FANOUT_MAX-1. Then init_done rises and the FSM moves to IDLE. cfg_we is ignored during INIT.
- IDLE: spk_ready=1. On spk_valid&&spk_ready, latch spk_neuron, set slot=0, and go to LOOKUP.
- LOOKUP: perform a synchronous table read of (neuron, slot).
  - Read data valid=0 at slot 0: increment stat_unrouted, go to IDLE.
  - valid=0 at slot>0: go to IDLE.
  - valid=1: go to SEND.
- SEND: inj_valid=1 with flit fields set as follows; all other flit fields are 0:
  - dest_x, dest_y, neuron_id taken from the entry
  - src_x=TILE_X, src_y=TILE_Y
- SEND exit on inj_ready:
  - If slot==FANOUT_MAX-1, go to IDLE.
  - Otherwise slot++ and go to LOOKUP.
- inj_valid and inj_flit are registered and stay stable until accepted.
- Receive path: an ej handshake pushes the flit into the FIFO if dest_x==TILE_X and dest_y==TILE_Y.
  - Otherwise the flit is consumed, dropped, and stat_misroute is incremented.
  - The FIFO head drives the dlv_* outputs; a dlv handshake pops it.
- ej_ready = FIFO not full. It is a register-only function and must never depend combinationally on ej_valid, because the router derives valid from ready.
- Config write: one-cycle table write. A read of the same address in the same cycle returns the old data.

## Timing
- Values after reset: spk_ready=0, inj_valid=0, init_done=0, dlv_valid=0, ej_ready=1, both statistics counters=0.
- The receive path is operational during INIT.
- The INIT duration is NUM_NEURONS*FANOUT_MAX cycles. spk_ready rises in the cycle after the last clear write.
- Transmit latency:
  - Spike accepted in cycle T: table read in T+1, first inj_valid in T+2.
  - Each later flit follows 2 cycles after the previous handshake.
  - Maximum rate is 1 flit per 2 cycles.
- If inj_ready is low, hold SEND indefinitely. spk_ready stays 0 until the FSM returns to IDLE.
- Receive latency: an ej handshake in cycle T gives dlv_valid in T+1.
  - Push and pop in the same cycle are allowed, including when the FIFO is full: push is allowed only if ej_ready was high, so a full FIFO blocks the push regardless of the pop.
  - ej_ready does not rise in the same cycle as a pop.
- Counters saturate at 0xFFFF.
- Reset mid-operation: the in-flight spike is abandoned, the FIFO is emptied, and INIT restarts. The router shares rst, so dropping inj_valid under reset is legal.

## Structure
- kf_pkg holds:
  - COORD_W and NEURON_W
  - spike_flit_t (fields dest_x, dest_y, src_x, src_y, neuron_id)
  - new typedef fanout_entry_t
  - new enum ni_tx_state_t
- Sub-module kf_ni_rx_fifo: synchronous FIFO with parameter RX_DEPTH and full/empty flags.
- The table is inferred as a simple dual-port RAM with registered read.

## Test plan
- Release reset, wait: init_done=1 exactly 1024 cycles after reset release (default parameters). Then a spike on neuron 5 → no flit, stat_unrouted=1, spk_ready back to 1 in 2 cycles.
- Neuron 3 slots 0..2 = (1,2,7), (0,0,9), (3,1,4), slot 3 invalid, inj_ready=1 → three flits in order at T+2, T+4, T+6, src=(TILE_X,TILE_Y), then IDLE.
- Same setup with inj_ready low for 5 cycles on the second flit → flit held stable, no duplicate or loss, total of 3 flits.
- All 4 slots of neuron 0 valid → 4 flits, no 5th lookup.
- Inject 5 local-addressed flits with dlv_ready=0, RX_DEPTH=4 → 4 accepted, ej_ready=0. Then one pop → ej_ready=1 next cycle, and the 5th flit is delivered in order.
- Flit dest (TILE_X+1,TILE_Y) on ej → not delivered, stat_misroute=1. Assert rst during SEND → inj_valid=0, INIT restarts.

Source files
------------

// File: rtl/kf_pkg.sv
// Shared types for the kf tile network interface: flit and fan-out entry
// layouts, transmit FSM states, and a saturating counter helper.
package kf_pkg;

  localparam int unsigned COORD_W  = 4;
  localparam int unsigned NEURON_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0]  dest_x;
    logic [COORD_W-1:0]  dest_y;
    logic [COORD_W-1:0]  src_x;
    logic [COORD_W-1:0]  src_y;
    logic [NEURON_W-1:0] neuron_id;
  } spike_flit_t;

  typedef struct packed {
    logic                valid;
    logic [COORD_W-1:0]  dest_x;
    logic [COORD_W-1:0]  dest_y;
    logic [NEURON_W-1:0] dest_neuron;
  } fanout_entry_t;

  typedef enum logic [1:0] {
    TX_INIT,
    TX_IDLE,
    TX_LOOKUP,
    TX_SEND
  } ni_tx_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/kf_ni_rx_fifo.sv
// Receive-side flit FIFO; full/empty decode only from registered occupancy so
// the router-facing ready never depends on same-cycle inputs.
module kf_ni_rx_fifo
  import kf_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  spike_flit_t wdata,
  output spike_flit_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  spike_flit_t      mem_q [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_c;
  logic             pop_c;

  assign push_c = push && !full;
  assign pop_c  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(RX_DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/kf_noc_ni.sv
// Tile network interface: expands local spikes into per-destination flits
// for the router and buffers router-delivered flits for the core.
module kf_noc_ni
  import kf_pkg::*;
#(
  parameter int unsigned TILE_X      = 0,
  parameter int unsigned TILE_Y      = 0,
  parameter int unsigned NUM_NEURONS = 256,
  parameter int unsigned FANOUT_MAX  = 4,
  parameter int unsigned RX_DEPTH    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      spk_valid,
  output logic                                      spk_ready,
  input  logic [NEURON_W-1:0]                       spk_neuron,
  output logic                                      inj_valid,
  input  logic                                      inj_ready,
  output spike_flit_t                               inj_flit,
  input  logic                                      ej_valid,
  output logic                                      ej_ready,
  input  spike_flit_t                               ej_flit,
  output logic                                      dlv_valid,
  input  logic                                      dlv_ready,
  output logic [NEURON_W-1:0]                       dlv_neuron,
  output logic [COORD_W-1:0]                        dlv_src_x,
  output logic [COORD_W-1:0]                        dlv_src_y,
  input  logic                                      cfg_we,
  input  logic [$clog2(NUM_NEURONS*FANOUT_MAX)-1:0] cfg_addr,
  input  fanout_entry_t                             cfg_wdata,
  output logic                                      init_done,
  output logic [15:0]                               stat_unrouted,
  output logic [15:0]                               stat_misroute
);

  localparam int unsigned TBL_DEPTH = NUM_NEURONS * FANOUT_MAX;
  localparam int unsigned ADDR_W    = $clog2(TBL_DEPTH);
  localparam int unsigned SLOT_W    = $clog2(FANOUT_MAX);

  ni_tx_state_t        state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [NEURON_W-1:0] neuron_q, neuron_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  spike_flit_t         inj_flit_q, inj_flit_d;
  logic [15:0]         unrouted_q, unrouted_d;
  logic                init_done_q, init_done_d;
  logic                spk_ready_q;
  logic                inj_valid_q;
  logic [15:0]         misroute_q;

  fanout_entry_t       tbl_mem [TBL_DEPTH];
  fanout_entry_t       rd_entry_q;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic                tbl_we_c;
  logic [ADDR_W-1:0]   tbl_waddr_c;
  fanout_entry_t       tbl_wdata_c;

  // Clear sweep owns the write port during INIT; config writes are dropped.
  assign tbl_we_c    = (state_q == TX_INIT) || cfg_we;
  assign tbl_waddr_c = (state_q == TX_INIT) ? clr_addr_q : cfg_addr;
  assign tbl_wdata_c = (state_q == TX_INIT) ? '0 : cfg_wdata;

  // Address the entry the FSM will examine next cycle in LOOKUP.
  assign rd_addr_c = (state_q == TX_IDLE) ? ADDR_W'({spk_neuron, SLOT_W'(0)})
                                          : ADDR_W'({neuron_q, slot_q + SLOT_W'(1)});

  always_ff @(posedge clk) begin
    if (tbl_we_c) tbl_mem[tbl_waddr_c] <= tbl_wdata_c;
    rd_entry_q <= tbl_mem[rd_addr_c];
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    neuron_d    = neuron_q;
    slot_d      = slot_q;
    inj_flit_d  = inj_flit_q;
    unrouted_d  = unrouted_q;
    init_done_d = init_done_q;
    unique case (state_q)
      TX_INIT: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(TBL_DEPTH - 1)) begin
          state_d     = TX_IDLE;
          init_done_d = 1'b1;
        end
      end
      TX_IDLE: begin
        if (spk_valid) begin
          neuron_d = spk_neuron;
          slot_d   = '0;
          state_d  = TX_LOOKUP;
        end
      end
      TX_LOOKUP: begin
        if (rd_entry_q.valid) begin
          inj_flit_d           = '0;
          inj_flit_d.dest_x    = rd_entry_q.dest_x;
          inj_flit_d.dest_y    = rd_entry_q.dest_y;
          inj_flit_d.src_x     = COORD_W'(TILE_X);
          inj_flit_d.src_y     = COORD_W'(TILE_Y);
          inj_flit_d.neuron_id = rd_entry_q.dest_neuron;
          state_d              = TX_SEND;
        end else begin
          // Only an empty first slot means the spike had nowhere to go.
          if (slot_q == '0) unrouted_d = sat_inc16(unrouted_q);
          state_d = TX_IDLE;
        end
      end
      TX_SEND: begin
        if (inj_ready) begin
          if (slot_q == SLOT_W'(FANOUT_MAX - 1)) begin
            state_d = TX_IDLE;
          end else begin
            slot_d  = slot_q + SLOT_W'(1);
            state_d = TX_LOOKUP;
          end
        end
      end
      default: state_d = TX_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TX_INIT;
      clr_addr_q  <= '0;
      neuron_q    <= '0;
      slot_q      <= '0;
      inj_flit_q  <= '0;
      unrouted_q  <= '0;
      init_done_q <= 1'b0;
      spk_ready_q <= 1'b0;
      inj_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      neuron_q    <= neuron_d;
      slot_q      <= slot_d;
      inj_flit_q  <= inj_flit_d;
      unrouted_q  <= unrouted_d;
      init_done_q <= init_done_d;
      spk_ready_q <= (state_d == TX_IDLE);
      inj_valid_q <= (state_d == TX_SEND);
    end
  end

  assign spk_ready     = spk_ready_q;
  assign inj_valid     = inj_valid_q;
  assign inj_flit      = inj_flit_q;
  assign init_done     = init_done_q;
  assign stat_unrouted = unrouted_q;

  // Receive path: local flits are queued, anything else is counted and dropped.
  logic        ej_hs_c;
  logic        ej_local_c;
  logic        rx_full;
  logic        rx_empty;
  spike_flit_t rx_head;

  assign ej_hs_c    = ej_valid && ej_ready;
  assign ej_local_c = (ej_flit.dest_x == COORD_W'(TILE_X)) &&
                      (ej_flit.dest_y == COORD_W'(TILE_Y));

  always_ff @(posedge clk) begin
    if (rst) begin
      misroute_q <= '0;
    end else if (ej_hs_c && !ej_local_c) begin
      misroute_q <= sat_inc16(misroute_q);
    end
  end

  kf_ni_rx_fifo #(
    .RX_DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (ej_hs_c && ej_local_c),
    .pop  (dlv_valid && dlv_ready),
    .wdata(ej_flit),
    .rdata(rx_head),
    .full (rx_full),
    .empty(rx_empty)
  );

  assign ej_ready      = !rx_full;
  assign dlv_valid     = !rx_empty;
  assign dlv_neuron    = rx_head.neuron_id;
  assign dlv_src_x     = rx_head.src_x;
  assign dlv_src_y     = rx_head.src_y;
  assign stat_misroute = misroute_q;

endmodule

// File: tb/tb_kf_noc_ni.sv
// Scoreboard bench for kf_noc_ni: directed spikes and ejected flits, with a
// negedge monitor comparing every injected and delivered flit against queues.
module tb_kf_noc_ni;
  import kf_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                spk_valid;
  logic                spk_ready;
  logic [NEURON_W-1:0] spk_neuron;
  logic                inj_valid;
  logic                inj_ready;
  spike_flit_t         inj_flit;
  logic                ej_valid;
  logic                ej_ready;
  spike_flit_t         ej_flit;
  logic                dlv_valid;
  logic                dlv_ready;
  logic [NEURON_W-1:0] dlv_neuron;
  logic [COORD_W-1:0]  dlv_src_x;
  logic [COORD_W-1:0]  dlv_src_y;
  logic                cfg_we;
  logic [9:0]          cfg_addr;
  fanout_entry_t       cfg_wdata;
  logic                init_done;
  logic [15:0]         stat_unrouted;
  logic [15:0]         stat_misroute;

  int errors = 0;
  int checks = 0;
  int inj_hs = 0;
  spike_flit_t inj_exp_q[$];
  spike_flit_t dlv_exp_q[$];

  always #5 clk = ~clk;

  kf_noc_ni dut (
    .clk(clk), .rst(rst),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_neuron(spk_neuron),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_flit(inj_flit),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_flit(ej_flit),
    .dlv_valid(dlv_valid), .dlv_ready(dlv_ready), .dlv_neuron(dlv_neuron),
    .dlv_src_x(dlv_src_x), .dlv_src_y(dlv_src_y),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .init_done(init_done), .stat_unrouted(stat_unrouted), .stat_misroute(stat_misroute)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic spike_flit_t mkf(input int dx, input int dy, input int sx,
                                      input int sy, input int n);
    spike_flit_t f;
    f.dest_x    = COORD_W'(dx);
    f.dest_y    = COORD_W'(dy);
    f.src_x     = COORD_W'(sx);
    f.src_y     = COORD_W'(sy);
    f.neuron_id = NEURON_W'(n);
    return f;
  endfunction

  task automatic cfg(input int addr, input int dx, input int dy, input int n);
    cfg_we    = 1'b1;
    cfg_addr  = 10'(addr);
    cfg_wdata = {1'b1, COORD_W'(dx), COORD_W'(dy), NEURON_W'(n)};
    step(1);
    cfg_we    = 1'b0;
  endtask

  // Table entries plus the flit this tile should emit for them (src = 0,0).
  task automatic cfg_exp(input int addr, input int dx, input int dy, input int n);
    cfg(addr, dx, dy, n);
    inj_exp_q.push_back(mkf(dx, dy, 0, 0, n));
  endtask

  task automatic spike(input int n);
    int guard = 0;
    while (!spk_ready && guard < 100) begin
      step(1);
      guard++;
    end
    if (!spk_ready) begin
      checks++;
      errors++;
      $display("FAIL spk_ready_timeout: actual=0 required=1");
    end
    spk_valid  = 1'b1;
    spk_neuron = NEURON_W'(n);
    step(1);
    spk_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!spk_ready && guard < 100) begin
      step(1);
      guard++;
    end
    chk("idle_timeout", 32'(spk_ready), 32'd1);
  endtask

  task automatic ej_send(input spike_flit_t f);
    int guard = 0;
    ej_valid = 1'b1;
    ej_flit  = f;
    while (!ej_ready && guard < 20) begin
      step(1);
      guard++;
    end
    chk("ej_ready_timeout", 32'(ej_ready), 32'd1);
    step(1);
    ej_valid = 1'b0;
  endtask

  task automatic init_phase(input bit with_rx);
    rst = 1'b0;
    for (int i = 1; i <= 1024; i++) begin
      if (with_rx && i == 10) begin
        ej_valid = 1'b1;
        ej_flit  = mkf(0, 0, 2, 3, 8'h11);
        dlv_exp_q.push_back(ej_flit);
      end
      if (with_rx && i == 11) ej_valid = 1'b0;
      step(1);
      if (i == 1023) chk("init_done_early", 32'(init_done), 32'd0);
      if (i == 1024) begin
        chk("init_done_1024", 32'(init_done), 32'd1);
        chk("spk_ready_after_init", 32'(spk_ready), 32'd1);
      end
    end
  endtask

  // Monitor: compares every presented flit; held flits are re-checked each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (inj_valid) begin
        if (inj_exp_q.size() == 0) begin
          if (inj_ready) begin
            checks++;
            errors++;
            $display("FAIL inj_unexpected: actual flit=0x%0h required=none", inj_flit);
          end
        end else begin
          chk("inj_flit", 32'(inj_flit), 32'(inj_exp_q[0]));
          if (inj_ready) begin
            void'(inj_exp_q.pop_front());
            inj_hs++;
          end
        end
      end
      if (dlv_valid && dlv_ready) begin
        if (dlv_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dlv_unexpected: actual neuron=0x%0h required=none", dlv_neuron);
        end else begin
          spike_flit_t e;
          e = dlv_exp_q.pop_front();
          chk("dlv_neuron", 32'(dlv_neuron), 32'(e.neuron_id));
          chk("dlv_src", 32'({dlv_src_x, dlv_src_y}), 32'({e.src_x, e.src_y}));
        end
      end
    end
  end

  initial begin
    int hs0;
    rst = 1'b1; spk_valid = 1'b0; spk_neuron = '0; inj_ready = 1'b0;
    ej_valid = 1'b0; ej_flit = '0; dlv_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    step(3);
    chk("rst_spk_ready", 32'(spk_ready), 32'd0);
    chk("rst_inj_valid", 32'(inj_valid), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_dlv_valid", 32'(dlv_valid), 32'd0);
    chk("rst_ej_ready", 32'(ej_ready), 32'd1);
    chk("rst_unrouted", 32'(stat_unrouted), 32'd0);
    chk("rst_misroute", 32'(stat_misroute), 32'd0);

    init_phase(1'b1);

    // Unrouted spike
    spike(5);
    chk("unrouted_busy", 32'(spk_ready), 32'd0);
    step(1);
    chk("unrouted_ready", 32'(spk_ready), 32'd1);
    chk("unrouted_cnt", 32'(stat_unrouted), 32'd1);
    chk("unrouted_noinj", 32'(inj_valid), 32'd0);

    // Neuron 3: three destinations, slot 3 empty
    inj_ready = 1'b1;
    cfg_exp(12, 1, 2, 7);
    cfg_exp(13, 0, 0, 9);
    cfg_exp(14, 3, 1, 4);
    spike(3);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("tx_pattern", 32'(inj_valid), 32'((k % 2) == 0));
    end
    step(1);
    chk("tx_last_lookup", 32'(spk_ready), 32'd0);
    step(1);
    chk("tx_back_idle", 32'(spk_ready), 32'd1);
    chk("tx_q_empty", 32'(inj_exp_q.size()), 32'd0);
    chk("tx_unrouted_same", 32'(stat_unrouted), 32'd1);

    // Same with backpressure on the second flit
    hs0 = inj_hs;
    inj_exp_q.push_back(mkf(1, 2, 0, 0, 7));
    inj_exp_q.push_back(mkf(0, 0, 0, 0, 9));
    inj_exp_q.push_back(mkf(3, 1, 0, 0, 4));
    spike(3);
    step(2);
    inj_ready = 1'b0;
    step(1);
    chk("bp_hold_valid", 32'(inj_valid), 32'd1);
    step(4);
    chk("bp_hold_busy", 32'(spk_ready), 32'd0);
    chk("bp_hold_valid2", 32'(inj_valid), 32'd1);
    step(1);
    inj_ready = 1'b1;
    wait_idle();
    chk("bp_flit_count", 32'(inj_hs - hs0), 32'd3);

    // Neuron 0: full fan-out, no fifth lookup
    cfg_exp(0, 2, 0, 1);
    cfg_exp(1, 0, 3, 2);
    cfg_exp(2, 1, 1, 3);
    cfg_exp(3, 3, 3, 255);
    spike(0);
    step(7);
    chk("full_fanout_busy", 32'(spk_ready), 32'd0);
    step(1);
    chk("full_fanout_idle", 32'(spk_ready), 32'd1);
    chk("full_fanout_q", 32'(inj_exp_q.size()), 32'd0);

    // Receive FIFO fill, backpressure, pop
    dlv_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dlv_exp_q.push_back(mkf(0, 0, k + 1, k, 8'h20 + k));
      ej_send(mkf(0, 0, k + 1, k, 8'h20 + k));
      if (k == 0) chk("rx_latency", 32'(dlv_valid), 32'd1);
    end
    chk("rx_full_ready", 32'(ej_ready), 32'd0);
    ej_valid = 1'b1;
    ej_flit  = mkf(0, 0, 5, 4, 8'h24);
    dlv_exp_q.push_back(ej_flit);
    step(2);
    chk("rx_full_hold", 32'(ej_ready), 32'd0);
    dlv_ready = 1'b1;
    chk("rx_pop_cycle", 32'(ej_ready), 32'd0);
    step(1);
    dlv_ready = 1'b0;
    chk("rx_after_pop", 32'(ej_ready), 32'd1);
    step(1);
    ej_valid  = 1'b0;
    dlv_ready = 1'b1;
    step(6);
    chk("rx_drained", 32'(dlv_exp_q.size()), 32'd0);
    chk("rx_empty", 32'(dlv_valid), 32'd0);

    // Misrouted flit
    ej_valid = 1'b1;
    ej_flit  = mkf(1, 0, 2, 2, 8'h55);
    step(1);
    ej_valid = 1'b0;
    step(1);
    chk("misroute_cnt", 32'(stat_misroute), 32'd1);
    chk("misroute_nodlv", 32'(dlv_valid), 32'd0);

    // Reset while SEND is stalled
    inj_ready = 1'b0;
    spike(3);
    step(1);
    chk("pre_rst_send", 32'(inj_valid), 32'd1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_inj", 32'(inj_valid), 32'd0);
    chk("mid_rst_init", 32'(init_done), 32'd0);
    chk("mid_rst_spk", 32'(spk_ready), 32'd0);
    chk("mid_rst_unrouted", 32'(stat_unrouted), 32'd0);
    chk("mid_rst_misroute", 32'(stat_misroute), 32'd0);
    init_phase(1'b0);
    inj_ready = 1'b1;
    spike(3);
    step(1);
    chk("cleared_table", 32'(stat_unrouted), 32'd1);
    chk("cleared_noinj", 32'(inj_valid), 32'd0);
    chk("final_inj_q", 32'(inj_exp_q.size()), 32'd0);
    chk("final_dlv_q", 32'(dlv_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
